// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage core: shadows EX/MEM/WB destination metadata,
// drives the EX operand forwarding selects and sequences load-use stalls and
// branch flushes for the IF/ID and ID/EX pipeline registers.
module hazard_forward_ctrl #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  reg_write_d,
    input  logic                  load_d,
    input  logic                  pc_src_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e
);

    localparam logic [1:0] FwdReg = 2'b00;
    localparam logic [1:0] FwdWb  = 2'b01;
    localparam logic [1:0] FwdMem = 2'b10;

    // Shadow pipeline metadata
    logic [REG_ADDR_W-1:0] e_rs1_q, e_rs1_d;
    logic [REG_ADDR_W-1:0] e_rs2_q, e_rs2_d;
    logic [REG_ADDR_W-1:0] e_rd_q, e_rd_d;
    logic                  e_reg_write_q, e_reg_write_d;
    logic                  e_load_q, e_load_d;
    logic [REG_ADDR_W-1:0] m_rd_q, m_rd_d;
    logic                  m_reg_write_q, m_reg_write_d;
    logic [REG_ADDR_W-1:0] w_rd_q, w_rd_d;
    logic                  w_reg_write_q, w_reg_write_d;

    logic lw_stall;
    logic flush_e_int;

    // Pick the youngest in-flight producer of src; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input logic [REG_ADDR_W-1:0] m_rd,
                                           input logic                  m_we,
                                           input logic [REG_ADDR_W-1:0] w_rd,
                                           input logic                  w_we);
        logic [1:0] sel;
        sel = FwdReg;
        if (m_we && (m_rd != '0) && (m_rd == src)) begin
            sel = FwdMem;
        end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
            sel = FwdWb;
        end
        return sel;
    endfunction

    // Hazard detection and output drive; everything is held low during reset.
    always_comb begin
        lw_stall    = e_load_q && (e_rd_q != '0) &&
                      ((e_rd_q == rs1_d) || (e_rd_q == rs2_d)) && !pc_src_e;
        flush_e_int = lw_stall || pc_src_e;

        forward_a_e = FwdReg;
        forward_b_e = FwdReg;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        if (rst) begin
            forward_a_e = fwd_sel(e_rs1_q, m_rd_q, m_reg_write_q, w_rd_q, w_reg_write_q);
            forward_b_e = fwd_sel(e_rs2_q, m_rd_q, m_reg_write_q, w_rd_q, w_reg_write_q);
            stall_f     = lw_stall;
            stall_d     = lw_stall;
            flush_d     = pc_src_e;
            flush_e     = flush_e_int;
        end
    end

    // Next-state: E takes a bubble on flush, otherwise the ID fields; M and W shift.
    always_comb begin
        e_rs1_d       = rs1_d;
        e_rs2_d       = rs2_d;
        e_rd_d        = rd_d;
        e_reg_write_d = reg_write_d;
        e_load_d      = load_d;
        if (flush_e_int) begin
            e_rs1_d       = '0;
            e_rs2_d       = '0;
            e_rd_d        = '0;
            e_reg_write_d = 1'b0;
            e_load_d      = 1'b0;
        end
        m_rd_d        = e_rd_q;
        m_reg_write_d = e_reg_write_q;
        w_rd_d        = m_rd_q;
        w_reg_write_d = m_reg_write_q;
    end

    // Stage registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_rs1_q       <= '0;
            e_rs2_q       <= '0;
            e_rd_q        <= '0;
            e_reg_write_q <= 1'b0;
            e_load_q      <= 1'b0;
            m_rd_q        <= '0;
            m_reg_write_q <= 1'b0;
            w_rd_q        <= '0;
            w_reg_write_q <= 1'b0;
        end else begin
            e_rs1_q       <= e_rs1_d;
            e_rs2_q       <= e_rs2_d;
            e_rd_q        <= e_rd_d;
            e_reg_write_q <= e_reg_write_d;
            e_load_q      <= e_load_d;
            m_rd_q        <= m_rd_d;
            m_reg_write_q <= m_reg_write_d;
            w_rd_q        <= w_rd_d;
            w_reg_write_q <= w_reg_write_d;
        end
    end

endmodule
